fork_join_ctrl: RTL and testbench
=================================

Name: fork_join_ctrl

Overview:
- Hardware fork/join controller: launches up to N_THR worker engines together with one-cycle start pulses ("fork").
- Tracks their one-cycle done pulses and signals completion according to a selectable join policy: join-all, join-any or join-none.
- Sits between a sequencing master and a bank of worker engines, and is the launching counterpart of the join-waiting side.
- Reports which worker finished first and the cycle count from fork to join.

Parameters:
- N_THR, 2, number of worker thread slots (2..16).
- ID_W, $clog2(N_THR) (min 1), width of first_id.
- CNT_W, 16, width of the elapsed-cycle counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  fork request, sampled only in IDLE.
- mode  in  2  join policy, captured with start: 00 join-all, 01 join-any, 10 join-none, 11 treated as join-all.
- mask  in  N_THR  worker slots to launch, captured with start.
- busy  out  1  high from the cycle after start is accepted until the joined cycle inclusive.
- thr_start  out  N_THR  one-cycle launch pulse per masked worker.
- thr_done  in  N_THR  one-cycle completion pulse from each worker.
- joined  out  1  one-cycle pulse when the join condition is met.
- first_id  out  ID_W  index of the first worker to finish; valid from the joined cycle until the next accepted start.
- done_vec  out  N_THR  sticky record of completed launched workers; cleared on fork.
- elapsed  out  CNT_W  cycles spent in WAIT; saturating; held after join.

Behaviour:
- Reset (synchronous, rst high at clk edge): state=IDLE; busy=0, thr_start=0, joined=0, first_id=0, done_vec=0, elapsed=0, internal pend=0, got_first=0. Reset mid-operation aborts immediately; no joined pulse is produced.
- IDLE:
  - start=1 at edge k: capture mode and mask into pend; go to FORK.
  - start is ignored in every other state; no queuing.
- FORK (cycle k+1):
  - thr_start=pend, busy=1, done_vec cleared, elapsed=0, got_first=0.
  - If mode=join-none or pend==0, go to JOIN; otherwise go to WAIT.
  - thr_done arriving in the FORK cycle belongs to the previous run and is ignored.
- WAIT:
  - Each cycle: done_vec |= thr_done & pend; elapsed increments, saturating at all-ones.
  - On the first cycle with any (thr_done & pend) set: first_id = lowest set index; got_first=1.
  - Join-all: go to JOIN when (done_vec | (thr_done & pend)) == pend.
  - Join-any: go to JOIN on the first qualifying done.
  - thr_done on an unmasked slot is ignored.
  - A repeat done from the same slot has no effect.
- JOIN: joined=1 for exactly one cycle, busy=1; next state IDLE, busy=0.
- Latency:
  - Start accepted at edge k → thr_start high in cycle k+1.
  - Completing done sampled at edge m → joined high in cycle m+1.
  - Join-none: joined in cycle k+2.
- After join-any, workers still running continue to update done_vec through IDLE until the next accepted start. first_id and elapsed do not change.
- Join-none or mask==0: first_id=0 and elapsed=0 at join.
- Simultaneous dones in one cycle: all are recorded; first_id takes the lowest index.

Test Plan:
- mask=11, mode=01, worker0 done 20 cycles and worker1 done 30 cycles after thr_start → joined once 1 cycle after worker0 done; first_id=0; elapsed=20; done_vec becomes 11 after worker1 finishes.
- Same stimulus with mode=00 → joined 1 cycle after worker1 done; first_id=0; elapsed=30; done_vec=11.
- mode=10, mask=11 → thr_start=11 in cycle k+1, joined in cycle k+2, busy low in k+3; later dones only set done_vec.
- mode=01, both dones in the same cycle at +15 → first_id=0, elapsed=15, done_vec=11, single joined pulse.
- Back-to-back:
  - start during WAIT is ignored.
  - A second start the cycle after joined is accepted, and done_vec clears in its FORK cycle.
  - mask=00 → no thr_start pulse, joined in cycle k+2.
- rst asserted mid-WAIT → next cycle: all outputs zero, state IDLE, no joined pulse; a subsequent start proceeds normally.

Source files
------------

// File: rtl/fork_join_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : fork_join_ctrl
//  Purpose  : Launches a masked set of worker engines and reports completion
//             under a join-all / join-any / join-none policy.
//  Revision : 1.0 - initial release
// ============================================================================
module fork_join_ctrl #(
    parameter int N_THR = 2,
    parameter int ID_W  = (N_THR > 2) ? $clog2(N_THR) : 1,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [N_THR-1:0] mask,
    output logic             busy,
    output logic [N_THR-1:0] thr_start,
    input  logic [N_THR-1:0] thr_done,
    output logic             joined,
    output logic [ID_W-1:0]  first_id,
    output logic [N_THR-1:0] done_vec,
    output logic [CNT_W-1:0] elapsed
);

    localparam logic [1:0] c_MODE_ANY  = 2'b01;
    localparam logic [1:0] c_MODE_NONE = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FORK = 2'd1,
        S_WAIT = 2'd2,
        S_JOIN = 2'd3
    } state_t;

    state_t             r_state;
    logic [1:0]         r_mode;
    logic [N_THR-1:0]   r_pend;
    logic               r_got_first;
    logic               r_busy;
    logic [N_THR-1:0]   r_thr_start;
    logic               r_joined;
    logic [ID_W-1:0]    r_first_id;
    logic [N_THR-1:0]   r_done_vec;
    logic [CNT_W-1:0]   r_elapsed;

    logic [N_THR-1:0]   w_new_done;
    logic [ID_W-1:0]    w_low_id;
    logic               w_join_hit;

    assign w_new_done = thr_done & r_pend;

    // Descending scan so the lowest set index is the one left standing.
    always_comb begin
        w_low_id = '0;
        for (int i = N_THR - 1; i >= 0; i--) begin
            if (w_new_done[i]) begin
                w_low_id = ID_W'(i);
            end
        end
    end

    // Mode 11 falls through to join-all.
    always_comb begin
        w_join_hit = 1'b0;
        if (r_mode == c_MODE_ANY) begin
            w_join_hit = |w_new_done;
        end else begin
            w_join_hit = ((r_done_vec | w_new_done) == r_pend);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_mode      <= 2'b00;
            r_pend      <= '0;
            r_got_first <= 1'b0;
            r_busy      <= 1'b0;
            r_thr_start <= '0;
            r_joined    <= 1'b0;
            r_first_id  <= '0;
            r_done_vec  <= '0;
            r_elapsed   <= '0;
        end else begin
            r_thr_start <= '0;
            r_joined    <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // Stragglers from a join-any run keep reporting until the next fork.
                    r_done_vec <= r_done_vec | w_new_done;
                    if (start) begin
                        r_pend      <= mask;
                        r_mode      <= mode;
                        r_thr_start <= mask;
                        r_busy      <= 1'b1;
                        r_done_vec  <= '0;
                        r_elapsed   <= '0;
                        r_got_first <= 1'b0;
                        r_first_id  <= '0;
                        r_state     <= S_FORK;
                    end
                end
                S_FORK: begin
                    if (r_mode == c_MODE_NONE || r_pend == '0) begin
                        r_joined <= 1'b1;
                        r_state  <= S_JOIN;
                    end else begin
                        r_state  <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    r_done_vec <= r_done_vec | w_new_done;
                    if (r_elapsed != {CNT_W{1'b1}}) begin
                        r_elapsed <= r_elapsed + 1'b1;
                    end
                    if (|w_new_done && !r_got_first) begin
                        r_first_id  <= w_low_id;
                        r_got_first <= 1'b1;
                    end
                    if (w_join_hit) begin
                        r_joined <= 1'b1;
                        r_state  <= S_JOIN;
                    end
                end
                S_JOIN: begin
                    r_done_vec <= r_done_vec | w_new_done;
                    r_busy     <= 1'b0;
                    r_state    <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy      = r_busy;
    assign thr_start = r_thr_start;
    assign joined    = r_joined;
    assign first_id  = r_first_id;
    assign done_vec  = r_done_vec;
    assign elapsed   = r_elapsed;

endmodule
`default_nettype wire

// File: tb/tb_fork_join_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fork_join_ctrl
//  Purpose  : Directed self-checking bench for fork_join_ctrl with a join
//             result scoreboard.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fork_join_ctrl;

    localparam int c_N_THR = 2;
    localparam int c_ID_W  = 1;
    localparam int c_CNT_W = 16;

    logic                 clk;
    logic                 rst;
    logic                 start;
    logic [1:0]           mode;
    logic [c_N_THR-1:0]   mask;
    logic                 busy;
    logic [c_N_THR-1:0]   thr_start;
    logic [c_N_THR-1:0]   thr_done;
    logic                 joined;
    logic [c_ID_W-1:0]    first_id;
    logic [c_N_THR-1:0]   done_vec;
    logic [c_CNT_W-1:0]   elapsed;

    fork_join_ctrl #(
        .N_THR (c_N_THR),
        .ID_W  (c_ID_W),
        .CNT_W (c_CNT_W)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .mode      (mode),
        .mask      (mask),
        .busy      (busy),
        .thr_start (thr_start),
        .thr_done  (thr_done),
        .joined    (joined),
        .first_id  (first_id),
        .done_vec  (done_vec),
        .elapsed   (elapsed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [c_ID_W-1:0]  fid;
        logic [c_CNT_W-1:0] el;
    } exp_t;

    exp_t sb[$];
    int   n_cmp  = 0;
    int   n_err  = 0;
    int   n_join = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge, sample 1 time unit later, and score any join pulse.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        if (joined === 1'b1) begin
            n_join++;
            if (sb.size() == 0) begin
                chk("unexpected_join", {31'd0, joined}, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("sb_first_id", {31'd0, first_id}, {31'd0, e.fid});
                chk("sb_elapsed", {16'd0, elapsed}, {16'd0, e.el});
            end
        end
    endtask

    task automatic launch(input logic [1:0] md, input logic [c_N_THR-1:0] m);
        start = 1'b1;
        mode  = md;
        mask  = m;
        tick();
        start = 1'b0;
        mode  = 2'b00;
        mask  = '0;
        chk("fork_thr_start", {30'd0, thr_start}, {30'd0, m});
        chk("fork_busy", {31'd0, busy}, 32'd1);
        chk("fork_done_vec", {30'd0, done_vec}, 32'd0);
    endtask

    task automatic pulse_done(input logic [c_N_THR-1:0] d);
        thr_done = d;
        tick();
        thr_done = '0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; mode = 2'b00; mask = '0; thr_done = '0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_thr_start", {30'd0, thr_start}, 32'd0);
        chk("rst_joined", {31'd0, joined}, 32'd0);
        chk("rst_first_id", {31'd0, first_id}, 32'd0);
        chk("rst_done_vec", {30'd0, done_vec}, 32'd0);
        chk("rst_elapsed", {16'd0, elapsed}, 32'd0);

        // Join-any: worker0 at +20, worker1 at +30.
        sb.push_back('{1'b0, 16'd20});
        launch(2'b01, 2'b11);
        repeat (20) tick();
        pulse_done(2'b01);
        chk("any_joined", {31'd0, joined}, 32'd1);
        chk("any_done_vec_mid", {30'd0, done_vec}, 32'd1);
        tick();
        chk("any_single_pulse", {31'd0, joined}, 32'd0);
        chk("any_busy_low", {31'd0, busy}, 32'd0);
        repeat (8) tick();
        pulse_done(2'b10);
        chk("any_done_vec_late", {30'd0, done_vec}, 32'd3);
        chk("any_first_id_hold", {31'd0, first_id}, 32'd0);
        chk("any_elapsed_hold", {16'd0, elapsed}, 32'd20);

        // Join-all with an ignored start during WAIT.
        sb.push_back('{1'b0, 16'd30});
        launch(2'b00, 2'b11);
        repeat (5) tick();
        start = 1'b1; mode = 2'b01; mask = 2'b01;
        tick();
        start = 1'b0; mode = 2'b00; mask = '0;
        chk("wait_start_ignored", {30'd0, thr_start}, 32'd0);
        repeat (14) tick();
        pulse_done(2'b01);
        chk("all_not_yet", {31'd0, joined}, 32'd0);
        chk("all_done_vec_mid", {30'd0, done_vec}, 32'd1);
        repeat (9) tick();
        pulse_done(2'b10);
        chk("all_joined", {31'd0, joined}, 32'd1);
        chk("all_done_vec", {30'd0, done_vec}, 32'd3);
        chk("all_busy_at_join", {31'd0, busy}, 32'd1);
        tick();

        // Join-none accepted the cycle after joined; done_vec clears on fork.
        sb.push_back('{1'b0, 16'd0});
        launch(2'b10, 2'b11);
        tick();
        chk("none_joined", {31'd0, joined}, 32'd1);
        chk("none_thr_start_off", {30'd0, thr_start}, 32'd0);
        tick();
        chk("none_busy_low", {31'd0, busy}, 32'd0);
        pulse_done(2'b01);
        chk("none_done_vec", {30'd0, done_vec}, 32'd1);
        chk("none_elapsed", {16'd0, elapsed}, 32'd0);

        // Simultaneous dones at +15.
        sb.push_back('{1'b0, 16'd15});
        launch(2'b01, 2'b11);
        repeat (15) tick();
        pulse_done(2'b11);
        chk("sim_joined", {31'd0, joined}, 32'd1);
        chk("sim_done_vec", {30'd0, done_vec}, 32'd3);
        tick();
        chk("sim_single_pulse", {31'd0, joined}, 32'd0);

        // Unmasked slot ignored; first_id picks the masked worker.
        sb.push_back('{1'b1, 16'd5});
        launch(2'b01, 2'b10);
        repeat (5) tick();
        pulse_done(2'b11);
        chk("unmask_joined", {31'd0, joined}, 32'd1);
        chk("unmask_done_vec", {30'd0, done_vec}, 32'd2);
        tick();

        // Empty mask.
        sb.push_back('{1'b0, 16'd0});
        launch(2'b00, 2'b00);
        tick();
        chk("mask0_joined", {31'd0, joined}, 32'd1);
        tick();

        // Reset mid-WAIT, then a fresh run.
        launch(2'b00, 2'b11);
        repeat (5) tick();
        pulse_done(2'b10);
        chk("pre_rst_done_vec", {30'd0, done_vec}, 32'd2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_joined", {31'd0, joined}, 32'd0);
        chk("mid_rst_first_id", {31'd0, first_id}, 32'd0);
        chk("mid_rst_done_vec", {30'd0, done_vec}, 32'd0);
        chk("mid_rst_elapsed", {16'd0, elapsed}, 32'd0);
        pulse_done(2'b01);
        repeat (3) tick();
        chk("mid_rst_idle_done_vec", {30'd0, done_vec}, 32'd0);
        sb.push_back('{1'b0, 16'd3});
        launch(2'b01, 2'b01);
        repeat (3) tick();
        pulse_done(2'b01);
        chk("post_rst_joined", {31'd0, joined}, 32'd1);
        repeat (2) tick();

        chk("join_count", n_join, 32'd7);
        chk("sb_empty", sb.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
